// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for a 2-way, 256-set, 4-word-line tag/data store.
// Handles CPU word loads/stores, dirty-victim write-back, line refill and request replay.
module dcache_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    output logic        cpu_ready,
    input  logic        cpu_we,
    input  logic [26:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wmask,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_rdata,
    output logic        cam_read_req,
    output logic [9:0]  cam_read_index,
    output logic [16:0] cam_read_tag,
    input  logic        cam_read_hit,
    input  logic [16:0] cam_read_tag_out,
    input  logic [31:0] cam_read_data,
    input  logic [1:0]  cam_read_flags,
    output logic [9:0]  cam_write_index,
    output logic        cam_write_req_data,
    output logic [31:0] cam_write_data,
    output logic [3:0]  cam_write_mask,
    output logic        cam_write_req_tag_flags,
    output logic [16:0] cam_write_tag,
    output logic [1:0]  cam_write_flags,
    output logic        mem_req,
    output logic        mem_we,
    output logic [26:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOOKUP   = 3'd1;
    localparam logic [2:0] WB_READ  = 3'd2;
    localparam logic [2:0] WB_WRITE = 3'd3;
    localparam logic [2:0] FILL     = 3'd4;
    localparam logic [2:0] FILL_TAG = 3'd5;
    localparam logic [2:0] REPLAY   = 3'd6;

    logic [2:0]  state_r, state_s;
    logic [1:0]  k_r, k_s;
    logic [26:0] req_addr_r;
    logic        req_we_r;
    logic [31:0] req_wdata_r;
    logic [3:0]  req_wmask_r;
    logic [16:0] victim_tag_r;
    logic [31:0] wb_data_r;
    logic        wb_first_r;
    logic        resp_valid_r;
    logic [31:0] rdata_r;

    logic [16:0] req_tag_s;
    logic [7:0]  req_set_s;
    logic [1:0]  req_word_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                                input logic [31:0] upd,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = base;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = upd[8*b +: 8];
            end else begin
                res[8*b +: 8] = base[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign req_tag_s      = req_addr_r[26:10];
    assign req_set_s      = req_addr_r[9:2];
    assign req_word_s     = req_addr_r[1:0];
    assign cpu_ready      = (state_r == IDLE);
    assign cpu_resp_valid = resp_valid_r;
    assign cpu_rdata      = rdata_r;
    // The store's way select depends on this tag, so it never changes mid-miss.
    assign cam_read_tag   = req_tag_s;

    // Next-state and word-counter sequencing.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        case (state_r)
            IDLE: begin
                if (cpu_req) begin
                    state_s = LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (cam_read_hit) begin
                    state_s = IDLE;
                end else if (cam_read_flags == 2'b11) begin
                    state_s = WB_READ;
                    k_s     = 2'd0;
                end else begin
                    state_s = FILL;
                    k_s     = 2'd0;
                end
            end
            WB_READ: begin
                state_s = WB_WRITE;
            end
            WB_WRITE: begin
                if (mem_ack && (k_r == 2'd3)) begin
                    state_s = FILL;
                    k_s     = 2'd0;
                end else if (mem_ack) begin
                    state_s = WB_READ;
                    k_s     = k_r + 2'd1;
                end else begin
                    state_s = WB_WRITE;
                end
            end
            FILL: begin
                if (mem_ack && (k_r == 2'd3)) begin
                    state_s = FILL_TAG;
                    k_s     = 2'd0;
                end else if (mem_ack) begin
                    k_s     = k_r + 2'd1;
                end else begin
                    state_s = FILL;
                end
            end
            FILL_TAG: begin
                state_s = REPLAY;
            end
            REPLAY: begin
                state_s = LOOKUP;
            end
            default: begin
                state_s = IDLE;
                k_s     = 2'd0;
            end
        endcase
    end

    // Store and bus strobes decoded from the current state.
    always_comb begin
        cam_read_req            = 1'b0;
        cam_read_index          = {req_set_s, req_word_s};
        cam_write_index         = {req_set_s, req_word_s};
        cam_write_req_data      = 1'b0;
        cam_write_data          = req_wdata_r;
        cam_write_mask          = req_wmask_r;
        cam_write_req_tag_flags = 1'b0;
        cam_write_tag           = req_tag_s;
        cam_write_flags         = 2'b11;
        mem_req                 = 1'b0;
        mem_we                  = 1'b0;
        mem_addr                = {req_tag_s, req_set_s, k_r};
        // Victim word arrives the cycle after WB_READ; later cycles use the held copy.
        mem_wdata               = wb_first_r ? cam_read_data : wb_data_r;
        case (state_r)
            IDLE: begin
                cam_read_req   = cpu_req;
                cam_read_index = cpu_addr[9:0];
            end
            LOOKUP: begin
                if (cam_read_hit && req_we_r) begin
                    cam_write_req_data      = 1'b1;
                    cam_write_req_tag_flags = 1'b1;
                end else begin
                    cam_write_req_data      = 1'b0;
                    cam_write_req_tag_flags = 1'b0;
                end
            end
            WB_READ: begin
                cam_read_req   = 1'b1;
                cam_read_index = {req_set_s, k_r};
            end
            WB_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {victim_tag_r, req_set_s, k_r};
            end
            FILL: begin
                mem_req            = 1'b1;
                cam_write_index    = {req_set_s, k_r};
                cam_write_mask     = 4'hF;
                cam_write_req_data = mem_ack;
                if (req_we_r && (k_r == req_word_s)) begin
                    cam_write_data = merge_bytes(mem_rdata, req_wdata_r, req_wmask_r);
                end else begin
                    cam_write_data = mem_rdata;
                end
            end
            FILL_TAG: begin
                cam_write_req_tag_flags = 1'b1;
                cam_write_flags         = {req_we_r, 1'b1};
            end
            REPLAY: begin
                cam_read_req = 1'b1;
            end
            default: begin
                cam_read_req = 1'b0;
            end
        endcase
    end

    // State, request capture, victim tracking and CPU response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            k_r          <= 2'd0;
            req_addr_r   <= 27'd0;
            req_we_r     <= 1'b0;
            req_wdata_r  <= 32'd0;
            req_wmask_r  <= 4'd0;
            victim_tag_r <= 17'd0;
            wb_data_r    <= 32'd0;
            wb_first_r   <= 1'b0;
            resp_valid_r <= 1'b0;
            rdata_r      <= 32'd0;
        end else begin
            state_r      <= state_s;
            k_r          <= k_s;
            wb_first_r   <= (state_r == WB_READ);
            resp_valid_r <= (state_r == LOOKUP) && cam_read_hit;
            if ((state_r == IDLE) && cpu_req) begin
                req_addr_r  <= cpu_addr;
                req_we_r    <= cpu_we;
                req_wdata_r <= cpu_wdata;
                req_wmask_r <= cpu_wmask;
            end
            if ((state_r == LOOKUP) && !cam_read_hit) begin
                victim_tag_r <= cam_read_tag_out;
            end
            if ((state_r == WB_WRITE) && wb_first_r) begin
                wb_data_r <= cam_read_data;
            end
            if ((state_r == LOOKUP) && cam_read_hit && !req_we_r) begin
                rdata_r <= cam_read_data;
            end
        end
    end

endmodule
